// File: rtl/btn_event_gen.sv
// Debounces a synchronized button level into one-cycle press/release/repeat events.
// Define BTN_REPEAT_EN to build the hold/repeat timer; otherwise repeat_evt is tied to 0.
module btn_event_gen #(
   parameter int unsigned DEB_CYCLES    = 50000,
   parameter int unsigned HOLD_CYCLES   = 25000000,
   parameter int unsigned REPEAT_CYCLES = 5000000,
   parameter int unsigned CNT_W         = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_sync,
   output logic press,
   // release/repeat are reserved words, hence the _evt suffix on those two events
   output logic release_evt,
   output logic repeat_evt,
   output logic pressed
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   localparam longint unsigned CNT_MAX  = (64'd1 << CNT_W) - 64'd1;
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

   if (64'(DEB_CYCLES) < 64'd2 || 64'(DEB_CYCLES) > CNT_MAX) begin : g_bad_deb
      $error("btn_event_gen: DEB_CYCLES out of range for CNT_W");
   end
   if (64'(HOLD_CYCLES) < 64'd1 || 64'(HOLD_CYCLES) > CNT_MAX) begin : g_bad_hold
      $error("btn_event_gen: HOLD_CYCLES out of range for CNT_W");
   end
   if (64'(REPEAT_CYCLES) < 64'd1 || 64'(REPEAT_CYCLES) > CNT_MAX) begin : g_bad_rep
      $error("btn_event_gen: REPEAT_CYCLES out of range for CNT_W");
   end

   state_t           state, state_nxt;
   logic [CNT_W-1:0] deb_cnt, deb_cnt_nxt;
   logic             press_nxt, release_nxt, pressed_nxt;
   logic             hold_start;

   // NOTE: every signal assigned here gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      state_nxt   = state;
      deb_cnt_nxt = deb_cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      pressed_nxt = pressed;
      hold_start  = 1'b0;
      case (state)
         IDLE: begin
            if (btn_sync) begin
               state_nxt   = DB_PRESS;
               deb_cnt_nxt = ONE;
            end
         end
         DB_PRESS: begin
            if (!btn_sync) begin
               state_nxt   = IDLE;
               deb_cnt_nxt = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt   = HELD;
               deb_cnt_nxt = '0;
               press_nxt   = 1'b1;
               pressed_nxt = 1'b1;
               hold_start  = 1'b1;
            end else begin
               deb_cnt_nxt = deb_cnt + ONE;
            end
         end
         HELD: begin
            if (!btn_sync) begin
               state_nxt   = DB_RELEASE;
               deb_cnt_nxt = ONE;
            end
         end
         DB_RELEASE: begin
            if (btn_sync) begin
               state_nxt   = HELD;
               deb_cnt_nxt = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt   = IDLE;
               deb_cnt_nxt = '0;
               release_nxt = 1'b1;
               pressed_nxt = 1'b0;
            end else begin
               deb_cnt_nxt = deb_cnt + ONE;
            end
         end
         default: begin
            state_nxt   = IDLE;
            deb_cnt_nxt = '0;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         deb_cnt     <= '0;
         press       <= 1'b0;
         release_evt <= 1'b0;
         pressed     <= 1'b0;
      end else begin
         state       <= state_nxt;
         deb_cnt     <= deb_cnt_nxt;
         press       <= press_nxt;
         release_evt <= release_nxt;
         pressed     <= pressed_nxt;
      end
   end

`ifdef BTN_REPEAT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt, hold_last;
   logic             rpt_phase, rpt_phase_nxt;
   logic             repeat_nxt;

   assign hold_last = rpt_phase ? REP_LAST : HOLD_LAST;

   // Counts only while in HELD; frozen in DB_RELEASE. A repeat falling due on the
   // edge that leaves HELD is dropped but still restarts the interval.
   always_comb begin
      hold_cnt_nxt  = hold_cnt;
      rpt_phase_nxt = rpt_phase;
      repeat_nxt    = 1'b0;
      if (hold_start) begin
         hold_cnt_nxt  = '0;
         rpt_phase_nxt = 1'b0;
      end else if (state == HELD) begin
         if (hold_cnt == hold_last) begin
            hold_cnt_nxt  = '0;
            rpt_phase_nxt = 1'b1;
            repeat_nxt    = btn_sync;
         end else begin
            hold_cnt_nxt = hold_cnt + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt   <= '0;
         rpt_phase  <= 1'b0;
         repeat_evt <= 1'b0;
      end else begin
         hold_cnt   <= hold_cnt_nxt;
         rpt_phase  <= rpt_phase_nxt;
         repeat_evt <= repeat_nxt;
      end
   end
`else
   assign repeat_evt = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with DEB=4, HOLD=20, REPEAT=8; repeat
// expectations apply only when BTN_REPEAT_EN is defined.
module tb_btn_event_gen;

   logic clk;
   logic rst;
   logic btn_sync;
   logic press;
   logic release_evt;
   logic repeat_evt;
   logic pressed;

`ifdef BTN_REPEAT_EN
   localparam logic RPT_BUILT = 1'b1;
`else
   localparam logic RPT_BUILT = 1'b0;
`endif

   btn_event_gen #(
      .DEB_CYCLES   (4),
      .HOLD_CYCLES  (20),
      .REPEAT_CYCLES(8),
      .CNT_W        (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_sync   (btn_sync),
      .press      (press),
      .release_evt(release_evt),
      .repeat_evt (repeat_evt),
      .pressed    (pressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic rst;
      logic btn;
      int   len;
      logic press;
      logic rel;
      logic rpt;
      logic pressed;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, act, exp);
      end
   endtask

   // Drive one sample, clock it in, then compare the registered outputs.
   task automatic step(input logic r, input logic b, input logic e_press,
                       input logic e_rel, input logic e_rpt, input logic e_pressed);
      rst      = r;
      btn_sync = b;
      @(posedge clk);
      #1;
      cyc++;
      check("press", press, e_press);
      check("release", release_evt, e_rel);
      check("repeat", repeat_evt, e_rpt & RPT_BUILT);
      check("pressed", pressed, e_pressed);
   endtask

   task automatic add(input logic r, input logic b, input int n, input logic p,
                      input logic rl, input logic rp, input logic pd);
      vecs.push_back('{r, b, n, p, rl, rp, pd});
   endtask

   initial begin
      rst      = 1'b1;
      btn_sync = 1'b0;

      // Reset, clean press, auto-repeat, release glitch, release
      add(1, 0, 2,  0, 0, 0, 0);
      add(0, 0, 2,  0, 0, 0, 0);
      add(0, 1, 3,  0, 0, 0, 0);   // edges 0..2
      add(0, 1, 1,  1, 0, 0, 1);   // edge 3: press
      add(0, 1, 19, 0, 0, 0, 1);   // edges 4..22
      add(0, 1, 1,  0, 0, 1, 1);   // edge 23: first repeat
      add(0, 1, 2,  0, 0, 0, 1);
      add(0, 0, 2,  0, 0, 0, 1);   // edges 26..27 glitch low
      add(0, 1, 5,  0, 0, 0, 1);   // edges 28..32
      add(0, 1, 1,  0, 0, 1, 1);   // edge 33: shifted repeat
      add(0, 1, 7,  0, 0, 0, 1);
      add(0, 1, 1,  0, 0, 1, 1);   // edge 41
      add(0, 0, 3,  0, 0, 0, 1);   // edges 42..44
      add(0, 0, 1,  0, 1, 0, 0);   // edge 45: release
      add(0, 0, 2,  0, 0, 0, 0);
      // Bounce 1,1,0,1,1,1,1 then uninterrupted repeat cadence
      add(0, 1, 2,  0, 0, 0, 0);
      add(0, 0, 1,  0, 0, 0, 0);
      add(0, 1, 3,  0, 0, 0, 0);
      add(0, 1, 1,  1, 0, 0, 1);   // edge 6: press
      add(0, 1, 19, 0, 0, 0, 1);
      add(0, 1, 1,  0, 0, 1, 1);   // edge 26
      add(0, 1, 7,  0, 0, 0, 1);
      add(0, 1, 1,  0, 0, 1, 1);   // edge 34
      add(0, 1, 7,  0, 0, 0, 1);
      add(0, 1, 1,  0, 0, 1, 1);   // edge 42
      add(0, 1, 3,  0, 0, 0, 1);
      // Reset while held with the button still down
      add(1, 1, 2,  0, 0, 0, 0);
      add(0, 1, 3,  0, 0, 0, 0);
      add(0, 1, 1,  1, 0, 0, 1);
      add(0, 1, 2,  0, 0, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         for (int k = 0; k < vecs[i].len; k++) begin
            step(vecs[i].rst, vecs[i].btn, vecs[i].press, vecs[i].rel,
                 vecs[i].rpt, vecs[i].pressed);
         end
      end

      // Release starting on the edge the first repeat falls due: repeat dropped
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, (i == 3), 0, 0, (i == 3));
      for (int i = 0; i < 19; i++) step(0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);      // edge 23: no repeat
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0);      // edge 26: release
      step(0, 0, 0, 0, 0, 0);

      // Longest low glitch that must not release, then a real release
      for (int i = 0; i < 4; i++) step(0, 1, (i == 3), 0, 0, (i == 3));
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, (i == 3), 0, (i != 3));
      // New press detectable the cycle after release
      for (int i = 0; i < 4; i++) step(0, 1, (i == 3), 0, 0, (i == 3));
      step(0, 1, 0, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
